// File: rtl/demux_pkg.sv
// Shared definitions for the stream demultiplexer: select sizing, error counter
// width and the select range check.
package demux_pkg;

  localparam int ERR_W_DEFAULT = 8;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic sel_valid(input int unsigned sel, input int unsigned n);
    return sel < n;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output register slice. The parent only asserts load when the slot
// is free, so a load always wins over a drain in the same cycle.
module demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_stream.sv
// Registered 1:N stream demultiplexer with broadcast and a saturating counter
// of beats dropped for an out-of-range select.
module demux_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = sel_width(N),
  parameter int ERR_W = ERR_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_bcast,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic [N*WIDTH-1:0] out_data,
  output logic               err_pulse,
  output logic [ERR_W-1:0]   err_count
);

  logic [N-1:0] free;
  logic [N-1:0] hit;
  logic [N-1:0] load;
  logic         sel_ok;
  logic         unicast_free;
  logic         accept;
  logic         drop;

  // A slot can take a beat if it is empty or draining this cycle; broadcast
  // needs every slot to be free so delivery is all or nothing.
  always_comb begin
    free         = ~out_valid | out_ready;
    sel_ok       = sel_valid(32'(in_sel), N);
    hit          = '0;
    unicast_free = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (32'(in_sel) == k) begin
        hit[k]       = 1'b1;
        unicast_free = free[k];
      end
    end
    if (in_bcast) begin
      in_ready = &free;
    end else if (sel_ok) begin
      in_ready = unicast_free;
    end else begin
      in_ready = 1'b1;
    end
    accept = in_valid && in_ready && !rst;
    load   = '0;
    if (accept) begin
      load = in_bcast ? {N{1'b1}} : hit;
    end
    drop = in_valid && !in_bcast && !sel_ok && !rst;
  end

  for (genvar k = 0; k < N; k++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[k]),
      .d     (in_data),
      .valid (out_valid[k]),
      .ready (out_ready[k]),
      .q     (out_data[k*WIDTH +: WIDTH])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= drop;
      if (drop && (err_count != {ERR_W{1'b1}})) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_demux_stream.sv
// Bench for demux_stream: three instances (N=4/W=8, N=3/W=8, N=5/W=16) checked
// every cycle against a slot-occupancy model, plus directed literal checks.
module tb_demux_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  localparam int NCH [3] = '{4, 3, 5};
  localparam int SW  [3] = '{2, 2, 3};

  logic        iv   [3];
  logic        ib   [3];
  logic [3:0]  isel [3];
  logic [15:0] idat [3];
  logic [15:0] ordy [3];

  logic        ir0, ir1, ir2;
  logic        ep0, ep1, ep2;
  logic [7:0]  ec0, ec1, ec2;
  logic [3:0]  ov0;
  logic [2:0]  ov1;
  logic [4:0]  ov2;
  logic [31:0] od0;
  logic [23:0] od1;
  logic [79:0] od2;

  demux_stream #(.WIDTH(8), .N(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0), .in_data(idat[0][7:0]),
    .in_sel(isel[0][1:0]), .in_bcast(ib[0]), .out_valid(ov0), .out_ready(ordy[0][3:0]),
    .out_data(od0), .err_pulse(ep0), .err_count(ec0));

  demux_stream #(.WIDTH(8), .N(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1), .in_data(idat[1][7:0]),
    .in_sel(isel[1][1:0]), .in_bcast(ib[1]), .out_valid(ov1), .out_ready(ordy[1][2:0]),
    .out_data(od1), .err_pulse(ep1), .err_count(ec1));

  demux_stream #(.WIDTH(16), .N(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir2), .in_data(idat[2]),
    .in_sel(isel[2][2:0]), .in_bcast(ib[2]), .out_valid(ov2), .out_ready(ordy[2][4:0]),
    .out_data(od2), .err_pulse(ep2), .err_count(ec2));

  int vectors;
  int miscompares;
  logic cmp_on;

  // Model: what each channel currently holds, and the drop bookkeeping.
  logic        mv    [3][16];
  logic [15:0] md    [3][16];
  logic        mpulse[3];
  int          mcnt  [3];

  function automatic logic [15:0] dut_valid(input int d);
    case (d)
      0:       return 16'(ov0);
      1:       return 16'(ov1);
      default: return 16'(ov2);
    endcase
  endfunction

  function automatic logic [15:0] dut_data(input int d, input int k);
    case (d)
      0:       return 16'(od0[k*8 +: 8]);
      1:       return 16'(od1[k*8 +: 8]);
      default: return od2[k*16 +: 16];
    endcase
  endfunction

  function automatic logic dut_ready(input int d);
    case (d)
      0:       return ir0;
      1:       return ir1;
      default: return ir2;
    endcase
  endfunction

  function automatic logic dut_pulse(input int d);
    case (d)
      0:       return ep0;
      1:       return ep1;
      default: return ep2;
    endcase
  endfunction

  function automatic logic [7:0] dut_count(input int d);
    case (d)
      0:       return ec0;
      1:       return ec1;
      default: return ec2;
    endcase
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare one instance against the model, then advance the model by the
  // edge that is about to happen using the inputs currently applied.
  task automatic model_step(input int d);
    int          n;
    logic [15:0] ev;
    logic [15:0] mask;
    logic        all_free, sel_free, f, er, acc, drop;
    n        = NCH[d];
    mask     = (d == 2) ? 16'hFFFF : 16'h00FF;
    ev       = '0;
    all_free = 1'b1;
    sel_free = 1'b0;
    for (int k = 0; k < n; k++) begin
      ev[k]    = mv[d][k];
      f        = !mv[d][k] || ordy[d][k];
      all_free = all_free && f;
      if (int'(isel[d]) == k) sel_free = f;
    end
    if (ib[d])                  er = all_free;
    else if (int'(isel[d]) < n) er = sel_free;
    else                        er = 1'b1;

    if (cmp_on) begin
      check_output($sformatf("d%0d out_valid", d), 64'(dut_valid(d)), 64'(ev));
      for (int k = 0; k < n; k++)
        if (mv[d][k])
          check_output($sformatf("d%0d out_data[%0d]", d, k), 64'(dut_data(d, k)), 64'(md[d][k]));
      if (!rst)
        check_output($sformatf("d%0d in_ready", d), 64'(dut_ready(d)), 64'(er));
      check_output($sformatf("d%0d err_pulse", d), 64'(dut_pulse(d)), 64'(mpulse[d]));
      check_output($sformatf("d%0d err_count", d), 64'(dut_count(d)), 64'(mcnt[d]));
    end

    if (rst) begin
      for (int k = 0; k < 16; k++) begin
        mv[d][k] = 1'b0;
        md[d][k] = '0;
      end
      mpulse[d] = 1'b0;
      mcnt[d]   = 0;
    end else begin
      acc  = iv[d] && er;
      drop = iv[d] && !ib[d] && (int'(isel[d]) >= n);
      for (int k = 0; k < n; k++) begin
        if (acc && (ib[d] || int'(isel[d]) == k)) begin
          mv[d][k] = 1'b1;
          md[d][k] = idat[d] & mask;
        end else if (mv[d][k] && ordy[d][k]) begin
          mv[d][k] = 1'b0;
        end
      end
      mpulse[d] = drop;
      if (drop && mcnt[d] < 255) mcnt[d]++;
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) model_step(d);
  end

  task automatic apply_stimulus(input int d, input logic v, input logic b,
                                input int sel, input logic [15:0] data);
    iv[d]   = v;
    ib[d]   = b;
    isel[d] = 4'(sel);
    idat[d] = data;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    for (int d = 0; d < 3; d++) begin
      apply_stimulus(d, 1'b0, 1'b0, 0, 16'h0);
      ordy[d]   = '0;
      mpulse[d] = 1'b0;
      mcnt[d]   = 0;
      for (int k = 0; k < 16; k++) begin
        mv[d][k] = 1'b0;
        md[d][k] = '0;
      end
    end
    cmp_on = 1'b1;

    step();
    step();
    rst = 1'b0;
    check_output("reset out_valid", 64'(ov0), 64'h0);
    check_output("reset out_data", 64'(od0), 64'h0);
    check_output("reset err_count", 64'(ec0), 64'h0);
    check_output("reset err_pulse", 64'(ep0), 64'h0);
    check_output("reset out_data w16", 64'(od2[63:0]), 64'h0);

    // Basic routing, one beat per channel on consecutive cycles.
    ordy[0] = 16'hF;
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(0, 1'b1, 1'b0, k, 16'(8'hA0 + k));
      step();
      check_output($sformatf("route valid %0d", k), 64'(ov0), 64'(4'b0001 << k));
      check_output($sformatf("route data %0d", k), 64'(od0[k*8 +: 8]), 64'(8'hA0 + k));
    end
    apply_stimulus(0, 1'b0, 1'b0, 0, 16'h0);
    step();
    check_output("route idle", 64'(ov0), 64'h0);

    // Back-pressure on channel 2 while channel 1 keeps flowing.
    ordy[0] = 16'b1011;
    apply_stimulus(0, 1'b1, 1'b0, 2, 16'hB0);
    step();
    apply_stimulus(0, 1'b1, 1'b0, 2, 16'hB1);
    #1;
    check_output("bp second blocked", 64'(ir0), 64'h0);
    step();
    check_output("bp first held", 64'(od0[23:16]), 64'hB0);
    apply_stimulus(0, 1'b1, 1'b0, 1, 16'hC1);
    #1;
    check_output("bp ch1 ready", 64'(ir0), 64'h1);
    step();
    check_output("bp ch1 data", 64'(od0[15:8]), 64'hC1);
    check_output("bp valid", 64'(ov0), 64'b0110);
    ordy[0] = 16'hF;
    apply_stimulus(0, 1'b1, 1'b0, 2, 16'hB1);
    #1;
    check_output("bp refill ready", 64'(ir0), 64'h1);
    step();
    check_output("bp second data", 64'(od0[23:16]), 64'hB1);
    check_output("bp second valid", 64'(ov0), 64'b0100);
    apply_stimulus(0, 1'b0, 1'b0, 0, 16'h0);
    step();

    // Broadcast must wait for the stalled slot 3.
    ordy[0] = 16'b0111;
    apply_stimulus(0, 1'b1, 1'b0, 3, 16'hD3);
    step();
    apply_stimulus(0, 1'b1, 1'b1, 0, 16'h5C);
    #1;
    check_output("bcast blocked", 64'(ir0), 64'h0);
    step();
    check_output("bcast no partial", 64'(ov0), 64'b1000);
    check_output("bcast slot3 held", 64'(od0[31:24]), 64'hD3);
    ordy[0] = 16'hF;
    #1;
    check_output("bcast ready", 64'(ir0), 64'h1);
    step();
    check_output("bcast valid", 64'(ov0), 64'hF);
    check_output("bcast data", 64'(od0), 64'h5C5C5C5C);
    apply_stimulus(0, 1'b0, 1'b0, 0, 16'h0);
    step();

    // Invalid select on the N=3 instance.
    ordy[1] = 16'h7;
    apply_stimulus(1, 1'b1, 1'b0, 3, 16'h77);
    #1;
    check_output("inv ready", 64'(ir1), 64'h1);
    step();
    check_output("inv pulse 1", 64'(ep1), 64'h1);
    check_output("inv count 1", 64'(ec1), 64'h1);
    step();
    check_output("inv pulse 2", 64'(ep1), 64'h1);
    check_output("inv count 2", 64'(ec1), 64'h2);
    apply_stimulus(1, 1'b0, 1'b0, 0, 16'h0);
    step();
    check_output("inv pulse off", 64'(ep1), 64'h0);
    check_output("inv count hold", 64'(ec1), 64'h2);
    check_output("inv no valid", 64'(ov1), 64'h0);
    apply_stimulus(1, 1'b1, 1'b0, 3, 16'h77);
    for (int i = 0; i < 300; i++) step();
    check_output("inv saturate", 64'(ec1), 64'd255);
    apply_stimulus(1, 1'b0, 1'b0, 0, 16'h0);
    step();

    // Mid-stream reset with slots 0 and 1 full and a beat pending.
    ordy[0] = 16'h0;
    apply_stimulus(0, 1'b1, 1'b0, 0, 16'hE0);
    step();
    apply_stimulus(0, 1'b1, 1'b0, 1, 16'hE1);
    step();
    check_output("mid full", 64'(ov0), 64'b0011);
    rst = 1'b1;
    apply_stimulus(0, 1'b1, 1'b0, 2, 16'hEE);
    step();
    check_output("mid reset valid", 64'(ov0), 64'h0);
    check_output("mid reset count", 64'(ec1), 64'h0);
    rst = 1'b0;
    apply_stimulus(0, 1'b0, 1'b0, 0, 16'h0);
    step();
    check_output("mid pending dropped", 64'(ov0), 64'h0);

    // Randomised traffic on every instance, checked by the model each cycle.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int d = 0; d < 3; d++) begin
        int sel;
        sel = ($urandom % 10 == 0) ? int'($urandom % (1 << SW[d])) : int'($urandom % NCH[d]);
        apply_stimulus(d, ($urandom % 4) != 0, ($urandom % 10) == 0, sel, 16'($urandom));
        ordy[d] = '0;
        for (int k = 0; k < NCH[d]; k++) ordy[d][k] = ($urandom % 10) < 7;
      end
      step();
    end
    for (int d = 0; d < 3; d++) apply_stimulus(d, 1'b0, 1'b0, 0, 16'h0);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
